// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI chip-select frames into auto-incrementing register-bus accesses
module spi_reg_bridge #(
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  in_data_valid,
  input  logic [7:0]            in_data,
  output logic                  out_data_valid,
  output logic [7:0]            out_data,
  input  logic                  out_data_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_write,
  output logic                  bus_read,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_rdata_valid,
  output logic                  error
);
  localparam int CW = $clog2(READ_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ_WAIT, READ_OFFER, READ_ARMED} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata, r_out_data;
  logic                  r_out_valid, r_write, r_read, r_error;
  logic [CW-1:0]         r_count;
  logic                  w_timeout;
  assign w_timeout      = r_count == CW'(READ_TIMEOUT);
  assign out_data_valid = r_out_valid;
  assign out_data       = r_out_data;
  assign bus_addr       = r_addr;
  assign bus_wdata      = r_wdata;
  assign bus_write      = r_write;
  assign bus_read       = r_read;
  assign error          = r_error;
  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state; a dropped chip select beats every other event
  always_comb begin
    w_next = r_state;
    if (!active) w_next = IDLE;
    else
      case (r_state)
        IDLE:       w_next = CMD;
        CMD:        if (in_data_valid) w_next = in_data[7] ? READ_WAIT : WRITE;
        READ_WAIT:  if (bus_rdata_valid || w_timeout) w_next = READ_OFFER;
        READ_OFFER: if (r_out_valid && out_data_ready) w_next = READ_ARMED;
        READ_ARMED: if (in_data_valid) w_next = READ_WAIT;
        default:    w_next = r_state;
      endcase
  end
  // datapath: bus strobes are one-cycle pulses, address advances after each access
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      if (r_write) r_addr <= r_addr + ADDR_WIDTH'(1);
      if (!active) begin
        r_out_valid <= 1'b0;
        r_count     <= '0;
      end else
        case (r_state)
          CMD: if (in_data_valid) begin
            r_addr  <= in_data[ADDR_WIDTH-1:0];
            r_read  <= in_data[7];
            r_count <= '0;
          end
          WRITE: if (in_data_valid) begin
            r_wdata <= in_data;
            r_write <= 1'b1;
          end
          READ_WAIT: begin
            r_count <= r_count + CW'(1);
            if (in_data_valid) r_error <= 1'b1;
            if (bus_rdata_valid) begin
              r_out_data  <= bus_rdata;
              r_out_valid <= 1'b1;
            end else if (w_timeout) begin
              r_out_data  <= 8'hFF;
              r_out_valid <= 1'b1;
              r_error     <= 1'b1;
            end
          end
          READ_OFFER: if (out_data_ready) r_out_valid <= 1'b0;
          READ_ARMED: if (in_data_valid) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_read  <= 1'b1;
            r_count <= '0;
          end
          default: r_count <= '0;
        endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed self-checking bench with a latency-programmable register responder
module tb_spi_reg_bridge;
  logic       clock = 1'b0;
  logic       reset, active, in_data_valid, out_data_ready;
  logic [7:0] in_data;
  logic       out_data_valid, bus_write, bus_read, error;
  logic [7:0] out_data, bus_wdata;
  logic [6:0] bus_addr;
  logic [7:0] bus_rdata;
  logic       bus_rdata_valid;
  int checks = 0, errors = 0;
  logic [7:0] regs [128];
  int lat = 0;
  int rd_cnt = 0;
  logic [6:0] rd_a;
  logic [6:0] wr_a_q [$];
  logic [7:0] wr_d_q [$];
  logic [6:0] rd_q [$];
  int overlap = 0;
  typedef struct {
    logic [7:0] cmd, d0, d1;
    int         gap;
    logic [6:0] a0, a1;
  } wvec_t;
  wvec_t tbl [4];
  spi_reg_bridge dut (
    .clock(clock), .reset(reset), .active(active),
    .in_data_valid(in_data_valid), .in_data(in_data),
    .out_data_valid(out_data_valid), .out_data(out_data), .out_data_ready(out_data_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid), .error(error)
  );
  always #5 clock = ~clock;
  // register responder (lat cycles after bus_read, 0 = never) and bus access log
  always @(negedge clock) begin
    bus_rdata_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus_rdata_valid = 1'b1;
        bus_rdata = regs[rd_a];
      end
    end
    if (bus_read && lat > 0) begin
      rd_a = bus_addr;
      rd_cnt = lat;
    end
    if (bus_read) rd_q.push_back(bus_addr);
    if (bus_write) begin
      wr_a_q.push_back(bus_addr);
      wr_d_q.push_back(bus_wdata);
    end
    if (bus_read && bus_write) overlap++;
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] b);
    in_data = b;
    in_data_valid = 1'b1;
    tick();
    in_data_valid = 1'b0;
  endtask
  task automatic start_frame();
    active = 1'b1;
    idle(2);
  endtask
  task automatic end_frame();
    active = 1'b0;
    idle(2);
  endtask
  task automatic wait_ovalid(input string nm);
    int n;
    n = 0;
    while (!out_data_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, out_data_valid, 1);
  endtask
  task automatic handshake(input string nm);
    out_data_ready = 1'b1;
    tick();
    out_data_ready = 1'b0;
    chk(nm, out_data_valid, 0);
  endtask
  function automatic logic [31:0] outs();
    return {5'd0, out_data_valid, out_data, bus_addr, bus_wdata, bus_write, bus_read, error};
  endfunction
  initial begin
    int base, seen;
    tbl[0] = '{8'h05, 8'hA1, 8'hB2, 2, 7'h05, 7'h06};
    tbl[1] = '{8'h7F, 8'h11, 8'h22, 2, 7'h7F, 7'h00};
    tbl[2] = '{8'h3C, 8'h5A, 8'hC3, 0, 7'h3C, 7'h3D};
    tbl[3] = '{8'h7E, 8'h00, 8'hFF, 0, 7'h7E, 7'h7F};
    regs[16] = 8'h11;
    regs[17] = 8'h22;
    reset = 1'b1;
    active = 1'b0;
    in_data_valid = 1'b0;
    in_data = 8'h00;
    out_data_ready = 1'b0;
    idle(3);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      base = wr_a_q.size();
      start_frame();
      strobe(tbl[i].cmd);
      idle(2);
      strobe(tbl[i].d0);
      chk("wr_latency0", bus_write, 1);
      idle(tbl[i].gap);
      strobe(tbl[i].d1);
      chk("wr_latency1", bus_write, 1);
      idle(2);
      end_frame();
      chk("wr_count", wr_a_q.size() - base, 2);
      if (wr_a_q.size() >= base + 2) begin
        chk("wr_addr0", wr_a_q[base], tbl[i].a0);
        chk("wr_data0", wr_d_q[base], tbl[i].d0);
        chk("wr_addr1", wr_a_q[base+1], tbl[i].a1);
        chk("wr_data1", wr_d_q[base+1], tbl[i].d1);
      end
      chk("wr_error", error, 0);
    end
    lat = 3;
    base = rd_q.size();
    start_frame();
    strobe(8'h90);
    chk("rd_latency0", bus_read, 1);
    chk("rd_addr0", bus_addr, 7'h10);
    wait_ovalid("rd_offer0");
    chk("rd_data0", out_data, 8'h11);
    idle(3);
    chk("rd_hold_valid", out_data_valid, 1);
    chk("rd_hold_data", out_data, 8'h11);
    handshake("rd_drop0");
    strobe(8'h00);
    chk("rd_latency1", bus_read, 1);
    chk("rd_addr1", bus_addr, 7'h11);
    wait_ovalid("rd_offer1");
    chk("rd_data1", out_data, 8'h22);
    handshake("rd_drop1");
    in_data = 8'h00;
    in_data_valid = 1'b1;
    active = 1'b0;
    tick();
    in_data_valid = 1'b0;
    idle(3);
    chk("rd_count", rd_q.size() - base, 2);
    if (rd_q.size() >= base + 2) begin
      chk("rd_log0", rd_q[base], 7'h10);
      chk("rd_log1", rd_q[base+1], 7'h11);
    end
    chk("rd_error", error, 0);
    lat = 4;
    start_frame();
    strobe(8'h85);
    chk("ab_read", bus_read, 1);
    tick();
    active = 1'b0;
    tick();
    chk("ab_valid", out_data_valid, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | int'(out_data_valid);
    end
    chk("ab_late_rdata", seen, 0);
    base = wr_a_q.size();
    start_frame();
    strobe(8'h02);
    idle(2);
    strobe(8'h33);
    chk("ab_next_write", bus_write, 1);
    chk("ab_next_addr", bus_addr, 7'h02);
    chk("ab_next_data", bus_wdata, 8'h33);
    idle(2);
    end_frame();
    chk("ab_next_count", wr_a_q.size() - base, 1);
    chk("ab_error", error, 0);
    lat = 20;
    start_frame();
    strobe(8'h83);
    chk("to_read", bus_read, 1);
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      seen = seen | int'(out_data_valid);
    end
    chk("to_early", seen, 0);
    tick();
    chk("to_valid", out_data_valid, 1);
    chk("to_data", out_data, 8'hFF);
    chk("to_error", error, 1);
    idle(6);
    chk("to_late_valid", out_data_valid, 1);
    chk("to_late_data", out_data, 8'hFF);
    handshake("to_drop");
    end_frame();
    chk("err_sticky", error, 1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("err_cleared", error, 0);
    lat = 0;
    start_frame();
    strobe(8'h81);
    chk("ov_read", bus_read, 1);
    strobe(8'hAA);
    chk("ov_error", error, 1);
    chk("ov_valid", out_data_valid, 0);
    reset = 1'b1;
    idle(2);
    chk("ov_reset_outputs", outs(), 0);
    reset = 1'b0;
    active = 1'b0;
    idle(2);
    chk("rw_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
